// File: rtl/clint_pkg.sv
// clint_pkg: register offsets, reset constants, bus request/response structs and
// decode/byte-lane helpers shared by the CLINT files.
package clint_pkg;

    localparam logic [15:0] msip_off        = 16'h0000;
    localparam logic [15:0] mtimecmp_lo_off = 16'h4000;
    localparam logic [15:0] mtimecmp_hi_off = 16'h4004;
    localparam logic [15:0] mtime_lo_off    = 16'hBFF8;
    localparam logic [15:0] mtime_hi_off    = 16'hBFFC;
    localparam logic [63:0] mtimecmp_rst    = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic {IDLE, RESP} state_e;

    typedef enum logic [2:0] {
        SEL_NONE, SEL_MSIP, SEL_CMP_LO, SEL_CMP_HI, SEL_TIME_LO, SEL_TIME_HI
    } sel_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } clint_in_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        ready;
    } clint_out_t;

    function automatic sel_e decode(input logic [31:0] addr, input logic [15:0] base_hi);
        if (addr[31:16] != base_hi || addr[1:0] != 2'b00) return SEL_NONE;
        return addr[15:0] == msip_off        ? SEL_MSIP    :
               addr[15:0] == mtimecmp_lo_off ? SEL_CMP_LO  :
               addr[15:0] == mtimecmp_hi_off ? SEL_CMP_HI  :
               addr[15:0] == mtime_lo_off    ? SEL_TIME_LO :
               addr[15:0] == mtime_hi_off    ? SEL_TIME_HI : SEL_NONE;
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [3:0] wstrb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (wstrb[i]) r[8*i +: 8] = wdata[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/clint_if.sv
// clint_if: request/response bus between a master and the CLINT register window.
interface clint_if;

    logic        clint_valid;
    logic [31:0] clint_addr;
    logic [31:0] clint_wdata;
    logic [3:0]  clint_wstrb;
    logic [31:0] clint_rdata;
    logic        clint_ready;

    modport master (
        output clint_valid, clint_addr, clint_wdata, clint_wstrb,
        input  clint_rdata, clint_ready
    );

    modport slave (
        input  clint_valid, clint_addr, clint_wdata, clint_wstrb,
        output clint_rdata, clint_ready
    );

endinterface

// File: rtl/clint_timer.sv
// clint_timer: 64-bit mtime with per-lane write ports; CLINT_PRESCALER_EN adds a
// divide-by-clint_divisor tick prescaler, otherwise mtime ticks every clock.
module clint_timer
    import clint_pkg::*;
#(
    parameter logic [7:0] clint_divisor = 8'd10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [63:0] mtime
);

    logic [63:0] mtime_q, mtime_d, mtime_inc;
    logic        tick;

`ifdef CLINT_PRESCALER_EN
    logic [7:0] presc_q, presc_d;

    always_comb begin
        tick    = clint_divisor <= 8'd1 || presc_q == clint_divisor - 8'd1;
        presc_d = tick ? 8'd0 : presc_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) presc_q <= '0;
        else     presc_q <= presc_d;
`else
    logic unused_div;
    assign unused_div = ^clint_divisor;
    assign tick       = 1'b1;
`endif

    // Unwritten lanes keep counting; a written lo half never carries into hi.
    always_comb begin
        mtime_inc = tick ? mtime_q + 64'd1 : mtime_q;
        mtime_d   = {wr_hi ? merge_lanes(mtime_inc[63:32], wdata, wstrb) : mtime_inc[63:32],
                     wr_lo ? merge_lanes(mtime_inc[31:0],  wdata, wstrb) : mtime_inc[31:0]};
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) mtime_q <= '0;
        else     mtime_q <= mtime_d;

    assign mtime = mtime_q;

endmodule

// File: rtl/clint.sv
// clint: core-local interruptor (msip, mtimecmp, mtime) behind a one-cycle-latency bus.
// Optional mtime prescaler is enabled by defining CLINT_PRESCALER_EN.
module clint
    import clint_pkg::*;
#(
    parameter logic [31:0] clint_base    = 32'h0200_0000,
    parameter logic [7:0]  clint_divisor = 8'd10
) (
    input  logic   clk,
    input  logic   rst,
    clint_if.slave bus,
    output logic   timer_irpt,
    output logic   soft_irpt
);

    state_e      state_q, state_d;
    clint_in_t   req_q, req_d;
    clint_out_t  rsp;
    sel_e        rd_sel, wr_sel;
    logic [31:0] rdata_q, rdata_d, rd_val;
    logic        msip_q, msip_d, tirq_q, tirq_d, sample;
    logic [63:0] cmp_q, cmp_d, mtime;

    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;

    always_comb state_d = (state_q == IDLE && bus.clint_valid) ? RESP : IDLE;

    always_comb begin
        rsp.ready       = state_q == RESP;
        rsp.rdata       = state_q == RESP ? rdata_q : '0;
        bus.clint_ready = rsp.ready;
        bus.clint_rdata = rsp.rdata;
    end

    // Read data is captured when the request is sampled; the write waits in RESP
    // and lands on the RESP->IDLE edge, so a reset during RESP drops it.
    always_comb begin
        sample  = state_q == IDLE && bus.clint_valid;
        req_d   = sample ? clint_in_t'{valid: 1'b1, addr: bus.clint_addr,
                                       wdata: bus.clint_wdata, wstrb: bus.clint_wstrb} : req_q;
        rd_sel  = decode(bus.clint_addr, clint_base[31:16]);
        rd_val  = rd_sel == SEL_MSIP    ? {31'd0, msip_q} :
                  rd_sel == SEL_CMP_LO  ? cmp_q[31:0]     :
                  rd_sel == SEL_CMP_HI  ? cmp_q[63:32]    :
                  rd_sel == SEL_TIME_LO ? mtime[31:0]     :
                  rd_sel == SEL_TIME_HI ? mtime[63:32]    : 32'd0;
        rdata_d = sample ? rd_val : rdata_q;
        wr_sel  = (state_q == RESP && req_q.valid && |req_q.wstrb)
                  ? decode(req_q.addr, clint_base[31:16]) : SEL_NONE;
        msip_d  = (wr_sel == SEL_MSIP && req_q.wstrb[0]) ? req_q.wdata[0] : msip_q;
        cmp_d   = {wr_sel == SEL_CMP_HI ? merge_lanes(cmp_q[63:32], req_q.wdata, req_q.wstrb) : cmp_q[63:32],
                   wr_sel == SEL_CMP_LO ? merge_lanes(cmp_q[31:0],  req_q.wdata, req_q.wstrb) : cmp_q[31:0]};
        tirq_d  = mtime >= cmp_q;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            req_q   <= '0;
            rdata_q <= '0;
            msip_q  <= 1'b0;
            cmp_q   <= mtimecmp_rst;
            tirq_q  <= 1'b0;
        end else begin
            req_q   <= req_d;
            rdata_q <= rdata_d;
            msip_q  <= msip_d;
            cmp_q   <= cmp_d;
            tirq_q  <= tirq_d;
        end

    clint_timer #(.clint_divisor(clint_divisor)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .wr_lo (wr_sel == SEL_TIME_LO),
        .wr_hi (wr_sel == SEL_TIME_HI),
        .wdata (req_q.wdata),
        .wstrb (req_q.wstrb),
        .mtime (mtime)
    );

    assign timer_irpt = tirq_q;
    assign soft_irpt  = msip_q;

endmodule

// File: tb/tb_clint.sv
// tb_clint: table-driven register checks plus hand sequences for timing, wrap and reset abort,
// with a read-data scoreboard and a reference model of msip/mtimecmp/mtime.
module tb_clint;

    localparam logic [31:0] base = 32'h0200_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic timer_irpt, soft_irpt;
    int   n_cmp = 0;
    int   n_bad = 0;

    clint_if bus_if ();

    clint #(.clint_base(base), .clint_divisor(8'd10)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
        .timer_irpt (timer_irpt),
        .soft_irpt  (soft_irpt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Reference model, updated on the edge where a transaction's write commits.
    logic [63:0] m_time, m_cmp, m_inc;
    logic        m_msip, m_tirq, m_tick;
    logic        wr_m = 1'b0;
    logic [31:0] wa_m = '0, wd_m = '0;
    logic [3:0]  ws_m = '0;

`ifdef CLINT_PRESCALER_EN
    logic [7:0] m_pc;
    assign m_tick = m_pc == 8'd9;
    always @(posedge clk or posedge rst) m_pc <= rst ? 8'd0 : m_tick ? 8'd0 : m_pc + 8'd1;
`else
    assign m_tick = 1'b1;
`endif

    assign m_inc = m_time + {63'd0, m_tick};

    function automatic logic [31:0] put(input logic [31:0] o, input logic [31:0] w, input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~m) | (w & m);
    endfunction

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return a == base            ? {31'd0, m_msip} :
               a == base + 32'h4000 ? m_cmp[31:0]     :
               a == base + 32'h4004 ? m_cmp[63:32]    :
               a == base + 32'hBFF8 ? m_time[31:0]    :
               a == base + 32'hBFFC ? m_time[63:32]   : 32'd0;
    endfunction

    always @(posedge clk or posedge rst)
        if (rst) begin
            m_time <= '0;
            m_cmp  <= '1;
            m_msip <= 1'b0;
            m_tirq <= 1'b0;
        end else begin
            m_tirq        <= m_time >= m_cmp;
            m_time[63:32] <= (wr_m && wa_m == base + 32'hBFFC) ? put(m_inc[63:32], wd_m, ws_m) : m_inc[63:32];
            m_time[31:0]  <= (wr_m && wa_m == base + 32'hBFF8) ? put(m_inc[31:0], wd_m, ws_m) : m_inc[31:0];
            if (wr_m && wa_m == base + 32'h4004) m_cmp[63:32] <= put(m_cmp[63:32], wd_m, ws_m);
            if (wr_m && wa_m == base + 32'h4000) m_cmp[31:0]  <= put(m_cmp[31:0], wd_m, ws_m);
            if (wr_m && wa_m == base && ws_m[0]) m_msip <= wd_m[0];
        end

    logic [31:0] sb[$];

    always @(negedge clk)
        if (!rst) begin
            if (bus_if.clint_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_ready: ready=1 with no request outstanding");
                end else check("rdata", bus_if.clint_rdata, sb.pop_front());
            end else check("rdata_idle", bus_if.clint_rdata, 0);
            check("soft_irpt", soft_irpt, m_msip);
            check("timer_irpt", timer_irpt, m_tirq);
        end

    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] want, input bit use_m, input string name);
        @(negedge clk);
        bus_if.clint_valid = 1'b1;
        bus_if.clint_addr  = a;
        bus_if.clint_wdata = d;
        bus_if.clint_wstrb = s;
        sb.push_back(use_m ? rd_model(a) : want);
        @(negedge clk);
        bus_if.clint_valid = 1'b0;
        check({name, "_ready"}, bus_if.clint_ready, 1);
        wr_m = |s;
        wa_m = a;
        wd_m = d;
        ws_m = s;
        @(negedge clk);
        wr_m = 1'b0;
        check({name, "_ready_drop"}, bus_if.clint_ready, 0);
    endtask

    task automatic wait_mtime(input logic [63:0] v, input string name);
        int k;
        k = 0;
        while (m_time != v && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check({name, "_reached"}, m_time, v);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] want;
    } vec_t;

    vec_t tbl[$];

    initial begin
        tbl.push_back('{base + 32'h4000, 32'h0,          4'h0, 32'hFFFF_FFFF});
        tbl.push_back('{base + 32'h4004, 32'h0,          4'h0, 32'hFFFF_FFFF});
        tbl.push_back('{base + 32'h4000, 32'h1234_5678,  4'h3, 32'hFFFF_FFFF});
        tbl.push_back('{base + 32'h4000, 32'h0,          4'h0, 32'hFFFF_5678});
        tbl.push_back('{base + 32'h4004, 32'hAABB_CCDD,  4'hC, 32'hFFFF_FFFF});
        tbl.push_back('{base + 32'h4004, 32'h0,          4'h0, 32'hAABB_FFFF});
        tbl.push_back('{base + 32'h4000, 32'h0,          4'h8, 32'hFFFF_5678});
        tbl.push_back('{base + 32'h4000, 32'h0,          4'h0, 32'h00FF_5678});
        tbl.push_back('{base + 32'h1000, 32'h0,          4'h0, 32'h0});
        tbl.push_back('{base + 32'h1000, 32'h55,         4'hF, 32'h0});
        tbl.push_back('{32'h0201_0000,   32'h0,          4'h0, 32'h0});
        tbl.push_back('{32'h0300_4000,   32'h0,          4'hF, 32'h0});
        tbl.push_back('{base + 32'h4000, 32'h0,          4'h0, 32'h00FF_5678});
        tbl.push_back('{base + 32'h4002, 32'h0,          4'h0, 32'h0});
        tbl.push_back('{base + 32'h0001, 32'h1,          4'hF, 32'h0});
        tbl.push_back('{base,            32'h0,          4'h0, 32'h0});
        tbl.push_back('{base,            32'h0000_0100,  4'hF, 32'h0});
        tbl.push_back('{base,            32'h0,          4'h0, 32'h0});

        bus_if.clint_valid = 1'b0;
        bus_if.clint_addr  = '0;
        bus_if.clint_wdata = '0;
        bus_if.clint_wstrb = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", bus_if.clint_ready, 0);
        check("rst_rdata", bus_if.clint_rdata, 0);
        check("rst_timer", timer_irpt, 0);
        check("rst_soft", soft_irpt, 0);
        rst = 1'b0;

        repeat (5) @(posedge clk);
`ifdef CLINT_PRESCALER_EN
        xfer(base + 32'hBFF8, 32'h0, 4'h0, 32'd0, 1'b0, "mtime_after_rst");
`else
        xfer(base + 32'hBFF8, 32'h0, 4'h0, 32'd5, 1'b0, "mtime_after_rst");
`endif

        foreach (tbl[i]) xfer(tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].want, 1'b0, $sformatf("vec%0d", i));

        xfer(base, 32'h1, 4'hF, 32'h0, 1'b0, "msip_w1");
        check("soft_set", soft_irpt, 1);
        xfer(base, 32'hFFFF_FFFE, 4'hF, 32'h1, 1'b0, "msip_w0");
        check("soft_clr", soft_irpt, 0);
        xfer(base, 32'h0, 4'h0, 32'h0, 1'b0, "msip_rd");

        @(negedge clk);
        bus_if.clint_valid = 1'b1;
        bus_if.clint_addr  = base;
        bus_if.clint_wstrb = 4'h0;
        sb.push_back(32'h0);
        sb.push_back(32'h0);
        @(negedge clk);
        check("b2b_ready0", bus_if.clint_ready, 1);
        @(negedge clk);
        check("b2b_resp_ignored", bus_if.clint_ready, 0);
        @(negedge clk);
        check("b2b_ready1", bus_if.clint_ready, 1);
        bus_if.clint_valid = 1'b0;
        @(negedge clk);
        check("b2b_done", bus_if.clint_ready, 0);

        xfer(base + 32'h4004, 32'h0,  4'hF, 32'h0, 1'b1, "cmp_hi0");
        xfer(base + 32'h4000, 32'h20, 4'hF, 32'h0, 1'b1, "cmp_lo20");
        xfer(base + 32'hBFFC, 32'h0,  4'hF, 32'h0, 1'b1, "mtime_hi0");
        xfer(base + 32'hBFF8, 32'h0,  4'hF, 32'h0, 1'b1, "mtime_lo0");
        wait_mtime(64'h20, "mtime20");
        check("tirq_lag", timer_irpt, 0);
        @(negedge clk);
        check("tirq_rise", timer_irpt, 1);
        xfer(base + 32'hBFF8, 32'h0, 4'h0, 32'h0, 1'b1, "mtime_rd");
        xfer(base + 32'h4000, 32'h100, 4'hF, 32'h0, 1'b1, "cmp_lo100");
        check("tirq_hold", timer_irpt, 1);
        @(negedge clk);
        check("tirq_fall", timer_irpt, 0);

        xfer(base + 32'h4000, 32'h10,        4'hF, 32'h0, 1'b1, "cmp_lo10");
        xfer(base + 32'hBFFC, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "mtime_hi_max");
        xfer(base + 32'hBFF8, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "mtime_lo_max");
        check("tirq_before_wrap", timer_irpt, 1);
        wait_mtime(64'h0, "mtime_wrap");
        check("tirq_wrap_lag", timer_irpt, 1);
        @(negedge clk);
        check("tirq_wrap_fall", timer_irpt, 0);
        xfer(base + 32'hBFFC, 32'h0, 4'h0, 32'h0, 1'b0, "mtime_hi_after_wrap");

`ifdef CLINT_PRESCALER_EN
        xfer(base + 32'hBFF8, 32'h0, 4'h0, 32'h0, 1'b1, "presc_rd0");
        repeat (10) @(negedge clk);
        xfer(base + 32'hBFF8, 32'h0, 4'h0, 32'h0, 1'b1, "presc_rd1");
`endif

        @(negedge clk);
        bus_if.clint_valid = 1'b1;
        bus_if.clint_addr  = base + 32'h4000;
        bus_if.clint_wdata = 32'h0;
        bus_if.clint_wstrb = 4'hF;
        @(posedge clk);
        #1;
        check("abort_in_resp", bus_if.clint_ready, 1);
        rst = 1'b1;
        bus_if.clint_valid = 1'b0;
        #1;
        check("abort_ready_low", bus_if.clint_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_ready", bus_if.clint_ready, 0);
        end
        xfer(base + 32'h4000, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0, "abort_cmp_lo");
        xfer(base + 32'h4004, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0, "abort_cmp_hi");

        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1);
    end

endmodule

// File: doc/clint.md
CLINT -- requirements
Module: clint

Interface
REQ-001 Parameter: clint_base, 32'h02000000, base address of the 64 KiB register window.
REQ-002 Parameter: clint_divisor, 8'd10, clocks per mtime tick when the prescaler is compiled in.
REQ-003 Port: clk  input  1  sole clock; all state on posedge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: clint_valid  input  1  request strobe.
REQ-006 Port: clint_addr  input  32  byte address.
REQ-007 Port: clint_wdata  input  32  write data.
REQ-008 Port: clint_wstrb  input  4  byte enables; 0 = read.
REQ-009 Port: clint_rdata  output  32  read data, qualified by clint_ready.
REQ-010 Port: clint_ready  output  1  one-cycle response pulse.
REQ-011 Port: timer_irpt  output  1  machine timer pending, to csr timer_irpt.
REQ-012 Port: soft_irpt  output  1  machine software pending, to csr soft_irpt.

Function
REQ-013 Register map (offset = addr - clint_base): msip 0x0000 (bit0 only), mtimecmp lo/hi 0x4000/0x4004, mtime lo/hi 0xBFF8/0xBFFC.
REQ-014 Hit = addr[31:16] == clint_base[31:16] and addr[1:0] == 0; miss or unmapped offset: read 0, write ignored, ready still returned.
REQ-015 FSM IDLE/RESP: IDLE with clint_valid=1 captures request and goes RESP; RESP drives clint_ready=1 for exactly one cycle and returns IDLE.
REQ-016 Latency: clint_ready asserts exactly 1 cycle after valid is sampled in IDLE; clint_valid in RESP is ignored.
REQ-017 Master deasserts valid in ready cycle; valid still high in the following IDLE cycle is a new request.
REQ-018 clint_rdata = selected register value captured at request sampling; 0 when not ready.
REQ-019 Writes apply per byte lane per wstrb on the RESP transition edge; msip ignores bits 31:1.
REQ-020 mtime is 64-bit, increments by 1 per tick, wraps 0xFFFF_FFFF_FFFF_FFFF -> 0 with no flag.
REQ-021 Write to mtime lo/hi in the same cycle as a tick: written lanes take write data, unwritten lanes take incremented value of the same half; no carry from written lo into hi.
REQ-022 timer_irpt registered: next = (mtime >= mtimecmp), unsigned 64-bit, using post-update values; 1-cycle lag after mtime/mtimecmp change.
REQ-023 soft_irpt = msip bit0 registered output, 1 cycle after write.
REQ-024 Interrupt outputs are level signals; cleared only by software writes or mtime wrap.

Reset
REQ-025 On rst=1 (asynchronous): state IDLE, clint_ready=0, clint_rdata=0, msip=0, mtime=0, mtimecmp=all ones, prescaler=0, timer_irpt=0, soft_irpt=0.
REQ-026 Reset mid-transaction aborts it: no write committed, no ready pulse after release.

Configuration
REQ-027 Macro CLINT_PRESCALER_EN defined: tick = prescaler counter reaching clint_divisor-1, counter then wraps to 0; divisor 0 or 1 treated as every clock.
REQ-028 CLINT_PRESCALER_EN undefined: tick every clock, no prescaler register, clint_divisor unused.

Structure
REQ-029 Register offsets and mtimecmp reset value SHALL live in the shared constants package; clint_in/clint_out struct types in the shared wires package.
REQ-030 One sub-module clint_timer SHALL hold prescaler and mtime with write ports; clint holds decode, FSM, msip, mtimecmp, compare.

Verification
REQ-031 Reset release, read 0xBFF8 after 5 idle clocks (no prescaler) -> rdata equals cycle count since reset, ready exactly 1 cycle after valid.
REQ-032 Write msip=1 -> soft_irpt=1 one cycle after ready; write msip=0xFFFF_FFFE -> soft_irpt=0, read returns 0.
REQ-033 mtimecmp=0x0000_0000_0000_0020, mtime from 0 -> timer_irpt rises one cycle after mtime reaches 0x20; raising mtimecmp to 0x100 clears it next cycle.
REQ-034 Write mtime lo=0xFFFF_FFFF, hi=0xFFFF_FFFF -> after wrap mtime=0, timer_irpt falls with mtimecmp=0x10.
REQ-035 CLINT_PRESCALER_EN, divisor=10 -> mtime increments once per 10 clocks; read unmapped 0x1000 -> rdata 0, ready pulse.
REQ-036 Assert rst while in RESP with pending write to mtimecmp -> mtimecmp stays all ones, no ready pulse.
